risc_mem_arbiter: RTL

- Shares one single-port synchronous memory between the processor's instruction-fetch requester and its data (load/store) requester.
- Sits between the datapath and the memory macro, replacing the separate instruction/data memories.
- Sequences each access as request → memory issue → response.
- Data accesses have priority; a starvation counter guarantees fetch forward progress.

---
 rtl/risc_mem_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/risc_mem_arbiter.sv
// risc_mem_arbiter: shares one single-port synchronous memory between the
// instruction-fetch requester and the data (load/store) requester.
// Data has priority; a starvation counter guarantees fetch forward progress.
module risc_mem_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned WCNT_W   = 2;
    localparam int unsigned STARVE_W = 4;

    localparam logic [WCNT_W-1:0]   WAIT_INIT  = WCNT_W'(RD_LAT - 1);
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic [STARVE_W-1:0] starve_q, starve_nxt;
    logic [WCNT_W-1:0]   wait_q, wait_nxt;
    logic                owner_d_q, owner_d_nxt;  // 1: data requester owns the access
    logic                we_q, we_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic                capture;
    logic                fetch_wins;

    logic                if_ack_nxt, d_ack_nxt, mem_en_nxt, mem_we_nxt, busy_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;

    // State, starvation counter, wait counter and access latches
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            wait_q    <= '0;
            owner_d_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            starve_q  <= starve_nxt;
            wait_q    <= wait_nxt;
            owner_d_q <= owner_d_nxt;
            we_q      <= we_nxt;
        end
    end

    // Arbitration and sequencing request -> issue -> (wait) -> response
    always_comb begin
        state_nxt   = state_q;
        starve_nxt  = starve_q;
        wait_nxt    = wait_q;
        owner_d_nxt = owner_d_q;
        we_nxt      = we_q;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;
        capture     = 1'b0;
        fetch_wins  = if_req && (!d_req || (starve_q == STARVE_TOP));

        unique case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_nxt   = ISSUE;
                    owner_d_nxt = !fetch_wins;
                    if (fetch_wins) begin
                        addr_nxt   = if_addr;
                        we_nxt     = 1'b0;
                        wdata_nxt  = '0;
                        starve_nxt = '0;
                    end else begin
                        addr_nxt  = d_addr;
                        we_nxt    = d_we;
                        wdata_nxt = d_wdata;
                        if (if_req && (starve_q != STARVE_MAX)) begin
                            starve_nxt = starve_q + STARVE_W'(1);
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    wait_nxt  = WAIT_INIT;
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    wait_nxt = wait_q - WCNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, derived from the next state
    always_comb begin
        mem_en_nxt   = (state_nxt == ISSUE);
        mem_we_nxt   = (state_nxt == ISSUE) && we_nxt;
        busy_nxt     = (state_nxt != IDLE);
        if_ack_nxt   = (state_nxt == RESP) && !owner_d_nxt;
        d_ack_nxt    = (state_nxt == RESP) && owner_d_nxt;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        if (capture) begin
            if (owner_d_q) begin
                d_rdata_nxt = mem_rdata;
            end else begin
                if_rdata_nxt = mem_rdata;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack    <= if_ack_nxt;
            d_ack     <= d_ack_nxt;
            if_rdata  <= if_rdata_nxt;
            d_rdata   <= d_rdata_nxt;
            mem_en    <= mem_en_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
